// File: rtl/fetch_queue.sv
// Instruction-fetch stage around the PC register: issues one instruction
// memory request at a time, buffers returned words in a small FIFO for
// decode, and computes the NextPC value fed back to the PC register.
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_IDLE  | no request outstanding
// ST_WAIT  | request outstanding, response will be queued
// ST_DRAIN | request outstanding, response will be dropped
module fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PC,
    output logic [31:0] NextPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [31:0]   q_instr_q [DEPTH];
    logic [31:0]   q_pc_q    [DEPTH];

    logic push;
    logic pop;
    logic flush;

    assign imem_req    = (state_q != ST_IDLE);
    assign imem_addr   = req_addr_q;
    assign instr_valid = (count_q != '0);
    assign instr       = instr_valid ? q_instr_q[rd_ptr_q] : 32'h0;
    assign instr_pc    = instr_valid ? q_pc_q[rd_ptr_q]    : 32'h0;

    // Request FSM: at most one request in flight, issued only when the queue has room
    always_comb begin
        state_d    = state_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    flush = 1'b1;
                end else if (count_q < CW'(DEPTH)) begin
                    req_addr_d = PC;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // Redirect wins over a same-cycle ack; the fetched word is stale.
                if (redirect) begin
                    flush   = 1'b1;
                    state_d = imem_ack ? ST_IDLE : ST_DRAIN;
                end else if (imem_ack) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Queue bookkeeping: flush clears everything and voids a same-cycle pop
    always_comb begin
        pop      = instr_valid && instr_ready && !flush;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    // NextPC: reset, then redirect, then sequential advance on an accepted ack
    always_comb begin
        if (!rst_n)
            NextPC = RESET_PC;
        else if (redirect)
            NextPC = {redirect_target[31:2], 2'b00};
        else if ((state_q == ST_WAIT) && imem_ack)
            NextPC = req_addr_q + 32'd4;
        else
            NextPC = PC;
    end

    // Control state and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            req_addr_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            req_addr_q <= req_addr_d;
        end
    end

    // Queue storage, written at the tail on push
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr_q[i] <= 32'h0;
                q_pc_q[i]    <= 32'h0;
            end
        end else if (push) begin
            q_instr_q[wr_ptr_q] <= imem_rdata;
            q_pc_q[wr_ptr_q]    <= req_addr_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue against a transaction-level model:
// one "outstanding request" record plus a FIFO of {pc, word} pairs.
module tb_fetch_queue;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC;
    logic [31:0] NextPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .PC              (PC),
        .NextPC          (NextPC),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .instr_valid     (instr_valid),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .instr_ready     (instr_ready)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    bit          m_out;
    bit          m_keep;
    logic [31:0] m_addr;
    logic [31:0] mq_pc[$];
    logic [31:0] mq_ins[$];

    logic [31:0] np;
    bit          rel_pending;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_out  = 0;
        m_keep = 0;
        m_addr = 32'h0;
        mq_pc.delete();
        mq_ins.delete();
    endtask

    task automatic model_flush();
        mq_pc.delete();
        mq_ins.delete();
    endtask

    task automatic model_step(input logic rd, input logic ak, input logic rdy,
                              input logic [31:0] pc, input logic [31:0] rdata);
        bit do_pop;
        do_pop = (mq_pc.size() != 0) && rdy;
        if (!m_out) begin
            if (rd) model_flush();
            else begin
                if (mq_pc.size() < DEPTH) begin
                    m_out  = 1;
                    m_keep = 1;
                    m_addr = pc;
                end
                if (do_pop) begin void'(mq_pc.pop_front()); void'(mq_ins.pop_front()); end
            end
        end else if (m_keep) begin
            if (rd) begin
                model_flush();
                if (ak) m_out = 0;
                else    m_keep = 0;
            end else begin
                if (do_pop) begin void'(mq_pc.pop_front()); void'(mq_ins.pop_front()); end
                if (ak) begin
                    mq_pc.push_back(m_addr);
                    mq_ins.push_back(rdata);
                    m_out = 0;
                end
            end
        end else begin
            if (ak) m_out = 0;
            if (do_pop) begin void'(mq_pc.pop_front()); void'(mq_ins.pop_front()); end
        end
    endtask

    function automatic logic [31:0] exp_next(input logic rd, input logic [31:0] tgt,
                                             input logic ak, input logic [31:0] pc);
        if (rd) return tgt & 32'hFFFF_FFFC;
        if (m_out && m_keep && ak) return m_addr + 32'd4;
        return pc;
    endfunction

    task automatic check_outputs(input logic rd, input logic [31:0] tgt, input logic ak);
        bit v;
        v = (mq_pc.size() != 0);
        check("imem_req",    {31'h0, imem_req},    {31'h0, m_out});
        check("imem_addr",   imem_addr,            m_addr);
        check("instr_valid", {31'h0, instr_valid}, {31'h0, v});
        check("instr",       instr,                v ? mq_ins[0] : 32'h0);
        check("instr_pc",    instr_pc,             v ? mq_pc[0]  : 32'h0);
        check("NextPC",      NextPC,               exp_next(rd, tgt, ak, PC));
    endtask

    // One clock: drive at negedge, check, then advance the model at posedge.
    // ack_pct applies while a request is visible; stray acks otherwise at 10%.
    task automatic cycle(input logic rd, input logic [31:0] tgt, input int ack_pct, input logic rdy);
        logic ak;
        @(negedge clk);
        if (rel_pending) begin
            rst_n = 1'b1;
            rel_pending = 0;
        end
        PC = np;
        if (imem_req) ak = ($urandom_range(0, 99) < ack_pct);
        else          ak = ($urandom_range(0, 9) == 0);
        redirect        = rd;
        redirect_target = tgt;
        imem_ack        = ak;
        imem_rdata      = $urandom;
        instr_ready     = rdy;
        #1;
        check_outputs(rd, tgt, ak);
        np = NextPC;
        @(posedge clk);
        model_step(rd, ak, rdy, PC, imem_rdata);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst imem_req",    {31'h0, imem_req},    32'h0);
        check("rst instr_valid", {31'h0, instr_valid}, 32'h0);
        check("rst imem_addr",   imem_addr,            32'h0);
        check("rst instr",       instr,                32'h0);
        check("rst instr_pc",    instr_pc,             32'h0);
        check("rst NextPC",      NextPC,               RST_PC);
        model_reset();
        redirect    = 1'b0;
        imem_ack    = 1'b0;
        instr_ready = 1'b0;
        np          = RST_PC;
        @(posedge clk);
        rel_pending = 1;
    endtask

    task automatic rand_phase(input int n, input int rdy_pct, input int ack_pct, input int rd_pct);
        logic        rd;
        logic [31:0] tgt;
        for (int i = 0; i < n; i++) begin
            rd = ($urandom_range(0, 99) < rd_pct);
            case ($urandom_range(0, 3))
                0:       tgt = 32'hFFFF_FFFC | ($urandom & 32'h3);
                default: tgt = $urandom & 32'h0000_0FFF;
            endcase
            cycle(rd, tgt, ack_pct, $urandom_range(0, 99) < rdy_pct);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        PC              = 32'h0;
        redirect        = 1'b0;
        redirect_target = 32'h0;
        imem_ack        = 1'b0;
        imem_rdata      = 32'h0;
        instr_ready     = 1'b0;
        model_reset();
        np          = RST_PC;
        rel_pending = 1;
        #1;
        check("init NextPC", NextPC, RST_PC);
        check("init imem_req", {31'h0, imem_req}, 32'h0);
        repeat (2) @(posedge clk);

        // Streaming with immediate acks and a ready consumer
        repeat (12) cycle(1'b0, 32'h0, 100, 1'b1);
        // Consumer stalled: queue fills and requests stop, then single pops
        repeat (10) cycle(1'b0, 32'h0, 100, 1'b0);
        cycle(1'b0, 32'h0, 100, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 100, 1'b0);

        // Redirect during a slow request: drain the late ack
        repeat (4) cycle(1'b0, 32'h0, 100, 1'b1);
        cycle(1'b0, 32'h0, 0, 1'b1);
        cycle(1'b0, 32'h0, 0, 1'b1);
        cycle(1'b1, 32'h0000_0103, 0, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 0, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 100, 1'b1);

        // Redirect colliding with an ack
        repeat (3) cycle(1'b0, 32'h0, 0, 1'b0);
        cycle(1'b1, 32'h0000_0200, 100, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 100, 1'b1);

        // Wrap of the sequential PC at the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 100, 1'b1);
        repeat (6) cycle(1'b0, 32'h0, 100, 1'b1);

        // Reset in the middle of a request at 0x40, then restart
        cycle(1'b1, 32'h0000_0040, 0, 1'b1);
        repeat (3) cycle(1'b0, 32'h0, 0, 1'b1);
        reset_pulse();
        repeat (8) cycle(1'b0, 32'h0, 100, 1'b1);

        rand_phase(400, 50, 40, 8);
        rand_phase(400, 80, 70, 4);
        reset_pulse();
        rand_phase(300, 20, 80, 15);
        rand_phase(300, 60, 50, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
